// File: rtl/adc_pkt_pkg.sv
// Shared definitions for the ADC FIFO packetizer: header magic, header
// field positions, FSM state encoding and the header builder.
package adc_pkt_pkg;

   localparam logic [7:0] HDR_MAGIC     = 8'hA5;
   localparam int         HDR_MAGIC_LSB = 24;
   localparam int         HDR_MODE_BIT  = 16;
   localparam int         HDR_SEQ_LSB   = 0;
   localparam int         HDR_SEQ_W     = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HEADER  = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_TRAILER = 2'd3
   } pkt_state_t;

   // Header word: magic in the top byte, mode flag, 16-bit sequence number.
   function automatic logic [31:0] make_header(input logic mode, input logic [15:0] seq);
      logic [31:0] hdr;
      hdr = '0;
      hdr[HDR_MAGIC_LSB +: 8]       = HDR_MAGIC;
      hdr[HDR_MODE_BIT]             = mode;
      hdr[HDR_SEQ_LSB +: HDR_SEQ_W] = seq;
      return hdr;
   endfunction

endpackage

// File: rtl/adc_fifo_64_packetizer_if.sv
// 32-bit valid/ready packet stream toward the host communication block.
interface adc_fifo_64_packetizer_if;
   logic [31:0] tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        tx_sop;
   logic        tx_eop;

   modport master (output tx_data, output tx_valid, output tx_sop, output tx_eop, input tx_ready);
   modport slave  (input tx_data, input tx_valid, input tx_sop, input tx_eop, output tx_ready);
endinterface

// File: rtl/fifo_read_stage.sv
// Turns normal-mode (1-cycle latency) FIFO reads into a 1-entry
// valid/take holding register. At most one read is in flight, and a new
// read may be issued in the same cycle the held word is taken.
module fifo_read_stage (
   input  logic        clock,
   input  logic        reset,
   output logic        fifo_rdreq,
   input  logic [63:0] fifo_q,
   input  logic        fifo_rdempty,
   output logic [63:0] word,
   output logic        word_valid,
   input  logic        word_take
);

   logic        pending_reg;
   logic        hold_valid_reg;
   logic [63:0] hold_data_reg;
   logic        slot_free;

   assign slot_free  = !pending_reg && (!hold_valid_reg || word_take);
   // Gated by reset so the request line is low for the whole reset pulse.
   assign fifo_rdreq = !reset && !fifo_rdempty && slot_free;
   assign word       = hold_data_reg;
   assign word_valid = hold_valid_reg;

   // Track the in-flight read and capture its data one cycle later.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pending_reg    <= 1'b0;
         hold_valid_reg <= 1'b0;
         hold_data_reg  <= '0;
      end else begin
         pending_reg <= fifo_rdreq;
         if (pending_reg) begin
            hold_valid_reg <= 1'b1;
            hold_data_reg  <= fifo_q;
         end else if (word_take) begin
            hold_valid_reg <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/adc_fifo_64_packetizer.sv
// Packetizer for the read side of the 64-bit ADC/averager FIFO.
// Frames averaged samples as header + PAYLOAD_WORDS payload beats on a
// 32-bit valid/ready stream. Atom mode splits each 64-bit word into two
// beats (upper half first); fast mode packs the low 16 bits of two
// consecutive words into one beat (first sample in bits [15:0]).
// Optional: define ADC_PKT_CHECKSUM_EN to append an XOR trailer beat.
module adc_fifo_64_packetizer
   import adc_pkt_pkg::*;
#(
   parameter int PAYLOAD_WORDS = 256,
   parameter int SEQ_BITS      = 16
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             enable,
   input  logic                             atom_nFast,
   output logic                             fifo_rdreq,
   input  logic [63:0]                      fifo_q,
   input  logic                             fifo_rdempty,
   adc_fifo_64_packetizer_if.master         tx,
   output logic                             busy
);

   localparam int CNT_W = $clog2(PAYLOAD_WORDS);

   pkt_state_t          state_reg, state_next;
   logic                mode_reg;
   logic [SEQ_BITS-1:0] seq_reg;
   logic [CNT_W-1:0]    beat_cnt_reg;
   logic                half_reg;
   logic                first_valid_reg;
   logic [15:0]         first_sample_reg;
`ifdef ADC_PKT_CHECKSUM_EN
   logic [31:0]         csum_reg;
`endif

   logic [63:0] word;
   logic        word_valid;
   logic        word_take;
   logic [31:0] payload_data;
   logic        payload_valid;
   logic        last_beat;
   logic        beat_fire;

   fifo_read_stage u_read_stage (
      .clock        (clock),
      .reset        (reset),
      .fifo_rdreq   (fifo_rdreq),
      .fifo_q       (fifo_q),
      .fifo_rdempty (fifo_rdempty),
      .word         (word),
      .word_valid   (word_valid),
      .word_take    (word_take)
   );

   // Fast mode only offers a beat once the first sample of the pair is stashed
   // and the second word is held, so a partial beat is never presented.
   assign payload_data  = mode_reg ? (half_reg ? word[31:0] : word[63:32])
                                   : {word[15:0], first_sample_reg};
   assign payload_valid = mode_reg ? word_valid : (word_valid && first_valid_reg);
   assign last_beat     = (beat_cnt_reg == CNT_W'(PAYLOAD_WORDS - 1));
   assign beat_fire     = (state_reg == ST_PAYLOAD) && payload_valid && tx.tx_ready;
   assign busy          = (state_reg != ST_IDLE);

   // FSM state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_reg <= ST_IDLE;
      else       state_reg <= state_next;
   end

   // FSM next state, stream outputs and holding-register consumption.
   always_comb begin
      state_next  = state_reg;
      tx.tx_valid = 1'b0;
      tx.tx_data  = '0;
      tx.tx_sop   = 1'b0;
      tx.tx_eop   = 1'b0;
      word_take   = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (enable) state_next = ST_HEADER;
         end
         ST_HEADER: begin
            tx.tx_valid = 1'b1;
            tx.tx_sop   = 1'b1;
            tx.tx_data  = make_header(mode_reg, 16'(seq_reg));
            if (tx.tx_ready) state_next = ST_PAYLOAD;
         end
         ST_PAYLOAD: begin
            tx.tx_valid = payload_valid;
            tx.tx_data  = payload_data;
`ifndef ADC_PKT_CHECKSUM_EN
            tx.tx_eop   = payload_valid && last_beat;
`endif
            // Stash the first sample of a fast-mode pair.
            if (!mode_reg && word_valid && !first_valid_reg) word_take = 1'b1;
            if (beat_fire) begin
               // Atom words are released after their lower half goes out.
               if (!mode_reg || half_reg) word_take = 1'b1;
`ifdef ADC_PKT_CHECKSUM_EN
               if (last_beat) state_next = ST_TRAILER;
`else
               if (last_beat) state_next = ST_IDLE;
`endif
            end
         end
`ifdef ADC_PKT_CHECKSUM_EN
         ST_TRAILER: begin
            tx.tx_valid = 1'b1;
            tx.tx_eop   = 1'b1;
            tx.tx_data  = csum_reg;
            if (tx.tx_ready) state_next = ST_IDLE;
         end
`endif
         default: state_next = ST_IDLE;
      endcase
   end

   // Mode latch, beat counting, fast-mode pairing and sequence number.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mode_reg         <= 1'b0;
         seq_reg          <= '0;
         beat_cnt_reg     <= '0;
         half_reg         <= 1'b0;
         first_valid_reg  <= 1'b0;
         first_sample_reg <= '0;
      end else begin
         if (state_reg == ST_IDLE && enable) mode_reg <= atom_nFast;
         if (state_reg == ST_HEADER) begin
            beat_cnt_reg    <= '0;
            half_reg        <= 1'b0;
            first_valid_reg <= 1'b0;
         end
         if (state_reg == ST_PAYLOAD && !mode_reg && word_valid && !first_valid_reg) begin
            first_sample_reg <= word[15:0];
            first_valid_reg  <= 1'b1;
         end
         if (beat_fire) begin
            beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
            if (mode_reg) half_reg        <= !half_reg;
            else          first_valid_reg <= 1'b0;
            if (last_beat) seq_reg <= seq_reg + SEQ_BITS'(1);
         end
      end
   end

`ifdef ADC_PKT_CHECKSUM_EN
   // Running XOR of the payload beats, cleared at each header.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         csum_reg <= '0;
      end else begin
         if (state_reg == ST_HEADER) csum_reg <= '0;
         else if (beat_fire)         csum_reg <= csum_reg ^ payload_data;
      end
   end
`endif

endmodule

// File: tb/tb_adc_fifo_64_packetizer.sv
// Randomized bench for adc_fifo_64_packetizer: a queue-based FIFO model
// feeds the DUT, and expected beats are built per packet from the framing
// rules (header, atom/fast payload, optional XOR trailer).
module tb_adc_fifo_64_packetizer;

   localparam int PW = 4;
   localparam int SB = 4;

   typedef struct packed {
      logic [31:0] data;
      logic        sop;
      logic        eop;
   } beat_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        enable;
   logic        atom_nFast;
   logic        fifo_rdreq;
   logic [63:0] fifo_q = '0;
   logic        fifo_rdempty = 1'b1;
   logic        busy;

   adc_fifo_64_packetizer_if tx_if ();

   adc_fifo_64_packetizer #(.PAYLOAD_WORDS(PW), .SEQ_BITS(SB)) dut (
      .clock        (clock),
      .reset        (reset),
      .enable       (enable),
      .atom_nFast   (atom_nFast),
      .fifo_rdreq   (fifo_rdreq),
      .fifo_q       (fifo_q),
      .fifo_rdempty (fifo_rdempty),
      .tx           (tx_if),
      .busy         (busy)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // FIFO model (normal mode): data appears the cycle after rdreq.
   logic [63:0] fifo_mem[$];
   logic        fifo_block = 1'b0;

   always @(posedge clock) begin
      if (fifo_rdreq) begin
         check_val("rdreq_while_empty", fifo_rdempty, 1'b0);
         if (fifo_mem.size() > 0) fifo_q <= fifo_mem.pop_front();
         else                     fifo_q <= 64'hDEAD_BEEF_DEAD_BEEF;
         fifo_rdempty <= fifo_block || (fifo_mem.size() <= 1);
      end else begin
         fifo_rdempty <= fifo_block || (fifo_mem.size() == 0);
      end
   end

   // Reference model state.
   beat_t exp_q[$];
   bit    mode_q[$];
   int    seq_model = 0;

   task automatic plan_packet(input bit mode, input logic [63:0] w[$]);
      beat_t       b;
      logic [31:0] pw;
      logic [31:0] csum;
      csum = '0;
      mode_q.push_back(mode);
      b.data = {8'hA5, 7'd0, mode, 16'(seq_model)};
      b.sop  = 1'b1;
      b.eop  = 1'b0;
      exp_q.push_back(b);
      for (int i = 0; i < PW; i++) begin
         if (mode) pw = (i % 2 == 0) ? w[i/2][63:32] : w[i/2][31:0];
         else      pw = {w[2*i+1][15:0], w[2*i][15:0]};
         csum  ^= pw;
         b.data = pw;
         b.sop  = 1'b0;
`ifdef ADC_PKT_CHECKSUM_EN
         b.eop  = 1'b0;
`else
         b.eop  = (i == PW - 1);
`endif
         exp_q.push_back(b);
      end
`ifdef ADC_PKT_CHECKSUM_EN
      b.data = csum;
      b.sop  = 1'b0;
      b.eop  = 1'b1;
      exp_q.push_back(b);
`endif
      foreach (w[i]) fifo_mem.push_back(w[i]);
      seq_model = (seq_model + 1) % (1 << SB);
   endtask

   task automatic plan_random(input bit mode);
      logic [63:0] w[$];
      int n;
      n = mode ? PW / 2 : 2 * PW;
      for (int i = 0; i < n; i++) w.push_back({$urandom(), $urandom()});
      plan_packet(mode, w);
   endtask

   // Drives enable/mode/ready, checks every accepted beat against exp_q.
   task automatic run_traffic(input int ready_mode, input bit use_blocks);
      int          cycle;
      int          block_cnt;
      int          eop_cycle;
      bit          stalled;
      bit          prev_valid;
      bit          have_eop;
      bit          last_pkt;
      bit          done;
      logic [31:0] held_data;
      logic        held_sop;
      logic        held_eop;
      beat_t       e;
      cycle = 0; block_cnt = 0; eop_cycle = 0;
      stalled = 0; prev_valid = 0; have_eop = 0; done = 0;
      held_data = '0; held_sop = 0; held_eop = 0;
      atom_nFast = mode_q.pop_front();
      last_pkt   = (mode_q.size() == 0);
      enable     = 1'b1;
      while (!done) begin
         @(negedge clock);
         cycle++;
         case (ready_mode)
            0:       tx_if.tx_ready = 1'b1;
            1:       tx_if.tx_ready = cycle[0];
            default: tx_if.tx_ready = 1'($urandom_range(0, 1));
         endcase
         if (use_blocks) begin
            if (block_cnt == 0 && $urandom_range(0, 40) == 0) block_cnt = 10;
            fifo_block = (block_cnt > 0);
            if (block_cnt > 0) block_cnt--;
         end
         #1;
         if (stalled) begin
            check_val("stall_valid", tx_if.tx_valid, 1'b1);
            check_val("stall_data", tx_if.tx_data, held_data);
            check_val("stall_sop", tx_if.tx_sop, held_sop);
            check_val("stall_eop", tx_if.tx_eop, held_eop);
         end
         if (tx_if.tx_valid && tx_if.tx_sop && !prev_valid && have_eop) begin
            check_val("b2b_gap", 64'(cycle - eop_cycle), 64'd2);
            have_eop = 0;
         end
         if (tx_if.tx_valid && tx_if.tx_ready) begin
            if (exp_q.size() == 0) begin
               check_val("extra_beat", 1'b1, 1'b0);
               done = 1;
            end else begin
               e = exp_q.pop_front();
               check_val("beat_data", tx_if.tx_data, e.data);
               check_val("beat_sop", tx_if.tx_sop, e.sop);
               check_val("beat_eop", tx_if.tx_eop, e.eop);
               if (e.sop) begin
                  check_val("busy_in_pkt", busy, 1'b1);
                  if (last_pkt) begin
                     enable     = 1'b0;
                     atom_nFast = ~atom_nFast;
                  end else begin
                     atom_nFast = mode_q.pop_front();
                     last_pkt   = (mode_q.size() == 0);
                  end
               end
               if (e.eop) begin
                  have_eop  = !last_pkt;
                  eop_cycle = cycle;
                  if (exp_q.size() == 0) done = 1;
               end
            end
         end
         stalled    = tx_if.tx_valid && !tx_if.tx_ready;
         held_data  = tx_if.tx_data;
         held_sop   = tx_if.tx_sop;
         held_eop   = tx_if.tx_eop;
         prev_valid = tx_if.tx_valid;
         if (cycle > 20000) begin
            check_val("timeout", 64'(exp_q.size()), 64'd0);
            done = 1;
         end
      end
      fifo_block     = 1'b0;
      tx_if.tx_ready = 1'b1;
      @(negedge clock); #1;
      check_val("busy_after_eop", busy, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clock); #1;
         check_val("idle_no_valid", tx_if.tx_valid, 1'b0);
      end
   endtask

   initial begin
      logic [63:0] w[$];
      int          guard;
      reset          = 1'b1;
      enable         = 1'b0;
      atom_nFast     = 1'b0;
      tx_if.tx_ready = 1'b0;
      repeat (3) @(negedge clock);
      #1;
      check_val("rst_valid", tx_if.tx_valid, 1'b0);
      check_val("rst_data", tx_if.tx_data, 32'h0);
      check_val("rst_sop", tx_if.tx_sop, 1'b0);
      check_val("rst_eop", tx_if.tx_eop, 1'b0);
      check_val("rst_busy", busy, 1'b0);
      check_val("rst_rdreq", fifo_rdreq, 1'b0);
      @(negedge clock);
      reset = 1'b0;

      // Directed atom packet then directed fast packet.
      w = {64'h0000_0001_0000_0002, 64'h0000_0003_0000_0004};
      plan_packet(1'b1, w);
      w = {64'hABCD_0000_0000_1111, 64'h0000_0000_1234_2222, 64'h0000_0000_0000_3333,
           64'hFFFF_FFFF_FFFF_4444, 64'h0000_0000_0000_5555, 64'h0000_0000_0000_6666,
           64'h0000_0000_0000_7777, 64'h0000_0000_0000_8888};
      plan_packet(1'b0, w);
      run_traffic(0, 1'b0);

      // Ready toggling each cycle with FIFO starvation windows.
      for (int i = 0; i < 20; i++) plan_random(1'($urandom_range(0, 1)));
      run_traffic(1, 1'b1);

      // Random ready, random modes, sequence wraps past 2^SB-1.
      for (int i = 0; i < 24; i++) plan_random(1'($urandom_range(0, 1)));
      run_traffic(2, 1'b1);

      // Reset mid-payload.
      plan_random(1'b1);
      tx_if.tx_ready = 1'b1;
      atom_nFast     = 1'b1;
      enable         = 1'b1;
      guard          = 0;
      do begin
         @(negedge clock); #1;
         guard++;
      end while (!(tx_if.tx_valid && !tx_if.tx_sop) && guard < 200);
      check_val("reset_wait_timeout", 64'(guard < 200), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      check_val("abort_valid", tx_if.tx_valid, 1'b0);
      check_val("abort_data", tx_if.tx_data, 32'h0);
      check_val("abort_sop", tx_if.tx_sop, 1'b0);
      check_val("abort_eop", tx_if.tx_eop, 1'b0);
      check_val("abort_busy", busy, 1'b0);
      check_val("abort_rdreq", fifo_rdreq, 1'b0);
      enable = 1'b0;
      fifo_mem.delete();
      exp_q.delete();
      mode_q.delete();
      seq_model = 0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      plan_random(1'b0);
      plan_random(1'b1);
      run_traffic(0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
